cm0_rst_seq_sync: RTL and testbench



---
 rtl/cm0_rst_pkg.sv | 27 ++
 rtl/cm0_rst_sync_chain.sv | 27 ++
 rtl/cm0_rst_seq_sync.sv | 195 +++++++++++++++++++
 tb/tb_cm0_rst_seq_sync.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cm0_rst_pkg.sv
// Shared types and limits for the cm0 reset synchroniser / release sequencer.
package cm0_rst_pkg;

  localparam int CNT_W          = 8;
  localparam int IDX_W          = 3;
  localparam int MAX_CH         = 8;
  localparam int MIN_SYNC_DEPTH = 2;
  localparam int MAX_SYNC_DEPTH = 4;
  localparam int MAX_CYC        = 255;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_STRETCH,
    ST_STAGGER,
    ST_RUN
  } rstState_e;

  function automatic bit paramsOk(input int present, input int numCh, input int depth,
                                  input int stretch, input int stagger);
    return ((present == 0) || (present == 1)) &&
           (numCh >= 1) && (numCh <= MAX_CH) &&
           (depth >= MIN_SYNC_DEPTH) && (depth <= MAX_SYNC_DEPTH) &&
           (stretch >= 0) && (stretch <= MAX_CYC) &&
           (stagger >= 0) && (stagger <= MAX_CYC);
  endfunction

endpackage

// File: rtl/cm0_rst_sync_chain.sv
// Deassertion synchroniser for an active-low asynchronous reset. Hand-instantiated cell
// boundary: keep the chain in this module so it is not restructured. SE is reserved for DFT.
module cm0_rst_sync_chain #(
  parameter int DEPTH = 3
) (
  input  logic CLK,
  input  logic RSTIN,
  input  logic SE,
  output logic Q
);

  logic [DEPTH-1:0] sync_q;
  logic             unusedSe;

  assign unusedSe = SE;

  always_ff @(posedge CLK or negedge RSTIN) begin
    if (!RSTIN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], 1'b1};
    end
  end

  assign Q = sync_q[DEPTH-1];

endmodule

// File: rtl/cm0_rst_seq_sync.sv
// Multi-channel reset synchroniser, stretcher and staggered release sequencer.
// Optional per-channel software reset is built when CM0_RST_SEQ_SWREQ_EN is defined.
module cm0_rst_seq_sync
  import cm0_rst_pkg::*;
#(
  parameter int PRESENT     = 1,
  parameter int NUM_CH      = 3,
  parameter int SYNC_DEPTH  = 3,
  parameter int STRETCH_CYC = 8,
  parameter int STAGGER_CYC = 4
) (
  input  logic              CLK,
  input  logic              RSTIN,
  input  logic              SE,
  input  logic              RSTBYPASS,
  input  logic [NUM_CH-1:0] SWRSTREQ,
  output logic [NUM_CH-1:0] RSTOUT,
  output logic              RSTDONE
);

  if (!paramsOk(PRESENT, NUM_CH, SYNC_DEPTH, STRETCH_CYC, STAGGER_CYC)) begin : gParamErr
    $error("cm0_rst_seq_sync: parameter out of range");
  end

  if (PRESENT == 0) begin : gAbsent
    logic unusedIns;
    assign unusedIns = ^{CLK, SE, RSTBYPASS, SWRSTREQ};
    assign RSTOUT    = {NUM_CH{RSTIN}};
    assign RSTDONE   = RSTIN;
  end else begin : gPresent

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH_CYC);
    localparam logic [CNT_W-1:0] STAGGER_LD = CNT_W'(STAGGER_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CH - 1);

    rstState_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_CH-1:0]  rel_q, rel_d;
    logic [NUM_CH-1:0]  out_q, out_d;
    logic               done_q, done_d;
    logic               relFirst;
    logic               rstSyncN;

    cm0_rst_sync_chain #(
      .DEPTH (SYNC_DEPTH)
    ) uSyncChain (
      .CLK   (CLK),
      .RSTIN (RSTIN),
      .SE    (SE),
      .Q     (rstSyncN)
    );

    // Sequencer: rel_* records which channels the power-on sequence has released.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      rel_d    = rel_q;
      relFirst = 1'b0;

      case (state_q)
        ST_ASSERT: begin
          rel_d = '0;
          if (rstSyncN) begin
            if (STRETCH_CYC == 0) begin
              relFirst = 1'b1;
            end else begin
              state_d = ST_STRETCH;
              cnt_d   = STRETCH_LD;
            end
          end
        end
        ST_STRETCH: begin
          if (cnt_q <= CNT_ONE) begin
            relFirst = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_STAGGER: begin
          if (cnt_q <= CNT_ONE) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (idx_q == IDX_W'(i)) begin
                rel_d[i] = 1'b1;
              end
            end
            if (idx_q == LAST_IDX) begin
              state_d = ST_RUN;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              cnt_d = STAGGER_LD;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_RUN: begin
        end
        default: begin
          state_d = ST_ASSERT;
        end
      endcase

      // A zero stagger releases every channel on the same edge as channel 0.
      if (relFirst) begin
        if ((STAGGER_CYC == 0) || (NUM_CH == 1)) begin
          rel_d   = '1;
          state_d = ST_RUN;
        end else begin
          rel_d[0] = 1'b1;
          state_d  = ST_STAGGER;
          idx_d    = IDX_W'(1);
          cnt_d    = STAGGER_LD;
        end
      end
    end

`ifdef CM0_RST_SEQ_SWREQ_EN
    localparam logic [CNT_W-1:0] SW_LD = (STRETCH_CYC == 0) ? CNT_ONE : CNT_W'(STRETCH_CYC);

    logic [NUM_CH-1:0] swAct_q, swAct_d;
    logic [NUM_CH-1:0] swReq;
    logic [CNT_W-1:0]  swCnt_q [NUM_CH];
    logic [CNT_W-1:0]  swCnt_d [NUM_CH];

    // A new request reloads the channel counter, so repeated requests extend the hold.
    always_comb begin
      swAct_d = swAct_q;
      swReq   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        swCnt_d[i] = swCnt_q[i];
        swReq[i]   = (state_q == ST_RUN) && SWRSTREQ[i];
        if (swReq[i]) begin
          swAct_d[i] = 1'b1;
          swCnt_d[i] = SW_LD;
        end else if (swAct_q[i]) begin
          if (swCnt_q[i] <= CNT_ONE) begin
            swAct_d[i] = 1'b0;
            swCnt_d[i] = '0;
          end else begin
            swCnt_d[i] = swCnt_q[i] - CNT_ONE;
          end
        end
      end
    end

    always_ff @(posedge CLK or negedge RSTIN) begin
      if (!RSTIN) begin
        swAct_q <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          swCnt_q[i] <= '0;
        end
      end else begin
        swAct_q <= swAct_d;
        for (int i = 0; i < NUM_CH; i++) begin
          swCnt_q[i] <= swCnt_d[i];
        end
      end
    end

    assign out_d  = rel_d & ~swAct_d;
    assign done_d = (state_q == ST_RUN) && (&out_q) && !(|swReq);
`else
    logic unusedSwReq;
    assign unusedSwReq = ^SWRSTREQ;
    assign out_d       = rel_d;
    assign done_d      = (state_q == ST_RUN) && (&out_q);
`endif

    always_ff @(posedge CLK or negedge RSTIN) begin
      if (!RSTIN) begin
        state_q <= ST_ASSERT;
        cnt_q   <= '0;
        idx_q   <= '0;
        rel_q   <= '0;
        out_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        idx_q   <= idx_d;
        rel_q   <= rel_d;
        out_q   <= out_d;
        done_q  <= done_d;
      end
    end

    // Outputs come straight from flops; the bypass mux is the only logic after them.
    assign RSTOUT  = RSTBYPASS ? {NUM_CH{RSTIN}} : out_q;
    assign RSTDONE = RSTBYPASS ? RSTIN : done_q;
  end

endmodule

// File: tb/tb_cm0_rst_seq_sync.sv
// Scoreboard bench for cm0_rst_seq_sync: default, fast (depth 2, no stretch/stagger)
// and absent (PRESENT=0) instances share clock and reset input.
module tb_cm0_rst_seq_sync;

  localparam int MODE_RESET   = 0;
  localparam int MODE_SEQ     = 1;
  localparam int MODE_SEQ_REQ = 2;
  localparam int MODE_SW_ONE  = 3;
  localparam int MODE_SW_TWO  = 4;
  localparam int SW_HOLD      = 8;
  localparam int DRAIN_LIMIT  = 100;

  typedef struct {
    string      tag;
    logic [2:0] mOut;
    logic       mDone;
    logic [2:0] fOut;
    logic       fDone;
  } expEntry_t;

  logic       clk = 1'b0;
  logic       clkEn = 1'b1;
  logic       rstIn = 1'b1;
  logic       se = 1'b0;
  logic       bypass = 1'b0;
  logic [2:0] swReq = 3'b000;
  logic [2:0] swZero = 3'b000;

  logic [2:0] mOut, fOut, offOut;
  logic       mDone, fDone, offDone;

  int checks = 0;
  int failures = 0;
  expEntry_t expQ[$];

  cm0_rst_seq_sync dut (
    .CLK (clk), .RSTIN (rstIn), .SE (se), .RSTBYPASS (bypass),
    .SWRSTREQ (swReq), .RSTOUT (mOut), .RSTDONE (mDone)
  );

  cm0_rst_seq_sync #(
    .SYNC_DEPTH (2), .STRETCH_CYC (0), .STAGGER_CYC (0)
  ) dutFast (
    .CLK (clk), .RSTIN (rstIn), .SE (se), .RSTBYPASS (bypass),
    .SWRSTREQ (swZero), .RSTOUT (fOut), .RSTDONE (fDone)
  );

  cm0_rst_seq_sync #(
    .PRESENT (0)
  ) dutOff (
    .CLK (clk), .RSTIN (rstIn), .SE (se), .RSTBYPASS (bypass),
    .SWRSTREQ (swZero), .RSTOUT (offOut), .RSTDONE (offDone)
  );

  always begin
    #5;
    if (clkEn) clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] seqOut(input int d, input int s, input int t, input int k);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (k >= d + s + 1 + i * t);
    return r;
  endfunction

  function automatic logic seqDone(input int d, input int s, input int t, input int k);
    return (k >= d + s + 1 + 2 * t + 1);
  endfunction

  // Scoreboard consumer: one expected entry per clock, sampled away from the rising edge.
  always @(negedge clk) begin : monitor
    expEntry_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({e.tag, "_mOut"}, 8'(mOut), 8'(e.mOut));
      checkOutput({e.tag, "_mDone"}, 8'(mDone), 8'(e.mDone));
      checkOutput({e.tag, "_fOut"}, 8'(fOut), 8'(e.fOut));
      checkOutput({e.tag, "_fDone"}, 8'(fDone), 8'(e.fDone));
      checkOutput({e.tag, "_offOut"}, 8'(offOut), 8'({3{rstIn}}));
      checkOutput({e.tag, "_offDone"}, 8'(offDone), 8'(rstIn));
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drainQueue(input string tag);
    int guard = 0;
    while (expQ.size() != 0 && guard < DRAIN_LIMIT) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (expQ.size() != 0) begin
      checkOutput({tag, "_drainTimeout"}, 8'(expQ.size()), 8'd0);
      expQ.delete();
    end
  endtask

  // Entry k holds the values expected just after the k-th rising edge from now.
  task automatic applyStimulus(input string tag, input int mode, input int n);
    expEntry_t e;
    int        relAt;
    for (int k = 1; k <= n; k++) begin
      e.tag = $sformatf("%s_e%0d", tag, k);
      relAt = (mode == MODE_SW_ONE) ? SW_HOLD : SW_HOLD + 4;
      case (mode)
        MODE_RESET: begin
          e.mOut = 3'b000; e.mDone = 1'b0; e.fOut = 3'b000; e.fDone = 1'b0;
        end
        MODE_SEQ, MODE_SEQ_REQ: begin
          e.mOut  = seqOut(3, 8, 4, k);
          e.mDone = seqDone(3, 8, 4, k);
          e.fOut  = seqOut(2, 0, 0, k);
          e.fDone = seqDone(2, 0, 0, k);
        end
        default: begin
`ifdef CM0_RST_SEQ_SWREQ_EN
          e.mOut  = ((k - 1) >= relAt) ? 3'b111 : 3'b101;
          e.mDone = ((k - 1) >= relAt + 1);
`else
          e.mOut  = 3'b111;
          e.mDone = 1'b1;
`endif
          e.fOut  = 3'b111;
          e.fDone = 1'b1;
        end
      endcase
      expQ.push_back(e);
    end
    case (mode)
      MODE_SEQ_REQ: begin
        waitCycles(13);
        swReq = 3'b101;
        waitCycles(2);
        swReq = 3'b000;
      end
      MODE_SW_ONE: begin
        swReq = 3'b010;
        waitCycles(1);
        swReq = 3'b000;
      end
      MODE_SW_TWO: begin
        swReq = 3'b010;
        waitCycles(1);
        swReq = 3'b000;
        waitCycles(3);
        swReq = 3'b010;
        waitCycles(1);
        swReq = 3'b000;
      end
      default: begin
      end
    endcase
    drainQueue(tag);
  endtask

  task automatic checkAll(input string tag, input logic [2:0] mExp, input logic mDoneExp);
    checkOutput({tag, "_mOut"}, 8'(mOut), 8'(mExp));
    checkOutput({tag, "_mDone"}, 8'(mDone), 8'(mDoneExp));
    checkOutput({tag, "_fOut"}, 8'(fOut), 8'(mExp));
    checkOutput({tag, "_fDone"}, 8'(fDone), 8'(mDoneExp));
    checkOutput({tag, "_offOut"}, 8'(offOut), 8'({3{rstIn}}));
    checkOutput({tag, "_offDone"}, 8'(offDone), 8'(rstIn));
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : stimulus
    logic [1:0] bypTab [5];
    logic [2:0] bypOut [5];

    #1 rstIn = 1'b0;
    #1 checkAll("asyncReset", 3'b000, 1'b0);
    applyStimulus("resetHold", MODE_RESET, 3);

    rstIn = 1'b1;
    applyStimulus("firstSeq", MODE_SEQ, 14);

    rstIn = 1'b0;
    #1 checkAll("midSeqAssert", 3'b000, 1'b0);
    applyStimulus("midSeqHold", MODE_RESET, 3);

    rstIn = 1'b1;
    applyStimulus("restartSeq", MODE_SEQ_REQ, 26);

    applyStimulus("swSingle", MODE_SW_ONE, 11);
    applyStimulus("swExtend", MODE_SW_TWO, 15);

    clkEn = 1'b0;
    #20;
    bypTab[0] = 2'b11; bypOut[0] = 3'b111;
    bypTab[1] = 2'b10; bypOut[1] = 3'b000;
    bypTab[2] = 2'b11; bypOut[2] = 3'b111;
    bypTab[3] = 2'b01; bypOut[3] = 3'b000;
    bypTab[4] = 2'b00; bypOut[4] = 3'b000;
    for (int i = 0; i < 5; i++) begin
      bypass = bypTab[i][1];
      rstIn  = bypTab[i][0];
      #2 checkAll($sformatf("bypass%0d", i), bypOut[i], bypOut[i][0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
